// File: rtl/alu_sequencer.sv
// Command/response sequencer that issues one operation at a time to a registered ALU.
// Define ALU_SEQ_CHECK_EN to add expected-result comparison (rsp_pass, err_count).
module alu_sequencer #(
    parameter int WIDTH       = 32,
    parameter int ALU_LATENCY = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WIDTH-1:0]     cmd_a,
    input  logic [WIDTH-1:0]     cmd_b,
    input  logic [2:0]           cmd_op,
    input  logic [WIDTH-1:0]     cmd_expect,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [2:0]           alu_op,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_zero,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_result,
    output logic                 rsp_zero,
    output logic [CNT_WIDTH-1:0] ops_count
`ifdef ALU_SEQ_CHECK_EN
    ,
    output logic                 rsp_pass,
    output logic [CNT_WIDTH-1:0] err_count
`endif
);

    localparam int CW = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;

`ifdef ALU_SEQ_CHECK_EN
    logic [WIDTH-1:0] expect_q;
`else
    logic unused_expect;
    assign unused_expect = ^cmd_expect;
`endif

    // The counter reaching zero marks the edge where the ALU result has settled.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= 3'b101;
            ops_count  <= '0;
`ifdef ALU_SEQ_CHECK_EN
            expect_q   <= '0;
            rsp_pass   <= 1'b0;
            err_count  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        alu_a     <= cmd_a;
                        alu_b     <= cmd_b;
                        alu_op    <= cmd_op;
                        wait_cnt  <= CW'(ALU_LATENCY);
                        cmd_ready <= 1'b0;
                        state     <= S_WAIT;
`ifdef ALU_SEQ_CHECK_EN
                        expect_q  <= cmd_expect;
`endif
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        rsp_result <= alu_result;
                        rsp_zero   <= alu_zero;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
`ifdef ALU_SEQ_CHECK_EN
                        rsp_pass   <= (alu_result == expect_q);
`endif
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                        if (ops_count != '1) begin
                            ops_count <= ops_count + CNT_WIDTH'(1);
                        end
`ifdef ALU_SEQ_CHECK_EN
                        if (!rsp_pass && (err_count != '1)) begin
                            err_count <= err_count + CNT_WIDTH'(1);
                        end
`endif
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: table-driven vectors with a response scoreboard,
// plus hand sequences for reset mid-operation, latency 3 and counter saturation.
`timescale 1ns/1ps
module tb_alu_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        clear;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_expect;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [15:0] ops_count;

    logic        l3_cmd_valid;
    logic        l3_cmd_ready;
    logic [31:0] l3_alu_a;
    logic [31:0] l3_alu_b;
    logic [2:0]  l3_alu_op;
    logic [31:0] l3_alu_result;
    logic        l3_alu_zero;
    logic        l3_rsp_valid;
    logic        l3_rsp_ready;
    logic [31:0] l3_rsp_result;
    logic        l3_rsp_zero;
    logic [1:0]  l3_ops_count;

`ifdef ALU_SEQ_CHECK_EN
    logic        rsp_pass;
    logic [15:0] err_count;
    logic        l3_rsp_pass;
    logic [1:0]  l3_err_count;
`endif

    alu_sequencer #(.WIDTH(32), .ALU_LATENCY(1), .CNT_WIDTH(16)) dut (
        .clock(clock), .clear(clear),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_expect(cmd_expect),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .ops_count(ops_count)
`ifdef ALU_SEQ_CHECK_EN
        , .rsp_pass(rsp_pass), .err_count(err_count)
`endif
    );

    alu_sequencer #(.WIDTH(32), .ALU_LATENCY(3), .CNT_WIDTH(2)) dut_l3 (
        .clock(clock), .clear(clear),
        .cmd_valid(l3_cmd_valid), .cmd_ready(l3_cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_expect(cmd_expect),
        .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_op(l3_alu_op),
        .alu_result(l3_alu_result), .alu_zero(l3_alu_zero),
        .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready),
        .rsp_result(l3_rsp_result), .rsp_zero(l3_rsp_zero),
        .ops_count(l3_ops_count)
`ifdef ALU_SEQ_CHECK_EN
        , .rsp_pass(l3_rsp_pass), .err_count(l3_err_count)
`endif
    );

    // Behavioural registered ALUs: one stage for the main DUT, three for dut_l3.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    logic [31:0] l3_pipe [3];

    always @(posedge clock) begin
        alu_result <= alu_fn(alu_a, alu_b, alu_op);
        l3_pipe[0] <= alu_fn(l3_alu_a, l3_alu_b, l3_alu_op);
        l3_pipe[1] <= l3_pipe[0];
        l3_pipe[2] <= l3_pipe[1];
    end

    assign alu_zero      = (alu_result == 32'd0);
    assign l3_alu_result = l3_pipe[2];
    assign l3_alu_zero   = (l3_alu_result == 32'd0);

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        pass;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] expv;
        logic [31:0] res;
        logic        zero;
        int          hold;
        bit          second;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ops_model = 0;
    int   err_model = 0;

    task automatic checkValue(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input logic [31:0] expv,
                                 input logic [31:0] res, input logic zero);
        int   n = 0;
        exp_t e;
        while (!cmd_ready && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        checkValue("cmd_ready_idle", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_a      = a;
        cmd_b      = b;
        cmd_op     = op;
        cmd_expect = expv;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        e.res  = res;
        e.zero = zero;
        e.pass = (res == expv);
        sb.push_back(e);
        checkValue("alu_a_issued", alu_a, a);
        checkValue("alu_op_issued", alu_op, op);
        checkValue("cmd_ready_busy", cmd_ready, 0);
    endtask

    task automatic checkOutput(input int hold, input bit second);
        int          n = 0;
        exp_t        e;
        logic [31:0] prev_a;
        prev_a = alu_a;
        while (!rsp_valid && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        checkValue("rsp_latency", n, 2);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty: actual=0 expected=1");
            return;
        end
        e = sb[0];
        checkValue("rsp_result", rsp_result, e.res);
        checkValue("rsp_zero", rsp_zero, e.zero);
`ifdef ALU_SEQ_CHECK_EN
        checkValue("rsp_pass", rsp_pass, e.pass);
`endif
        checkValue("cmd_ready_in_resp", cmd_ready, 0);
        for (int i = 0; i < hold; i++) begin
            if (second) begin
                cmd_valid  = 1'b1;
                cmd_a      = 32'd1;
                cmd_b      = 32'd2;
                cmd_op     = 3'b000;
                cmd_expect = 32'd3;
            end
            @(posedge clock); #1;
            checkValue("hold_rsp_valid", rsp_valid, 1);
            checkValue("hold_rsp_result", rsp_result, e.res);
            checkValue("hold_cmd_ready", cmd_ready, 0);
            checkValue("hold_alu_a", alu_a, prev_a);
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        void'(sb.pop_front());
        ops_model++;
        if (!e.pass) err_model++;
        checkValue("rsp_valid_cleared", rsp_valid, 0);
        checkValue("cmd_ready_after", cmd_ready, 1);
        checkValue("ops_count", ops_count, ops_model);
`ifdef ALU_SEQ_CHECK_EN
        checkValue("err_count", err_count, err_model);
`endif
    endtask

    vec_t vecs[12];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        vecs[0]  = '{32'd805, 32'd302, 3'b000, 32'd1107, 32'd1107, 1'b0, 0, 1'b0};
        vecs[1]  = '{32'd805, 32'd805, 3'b001, 32'd0, 32'd0, 1'b1, 0, 1'b0};
        vecs[2]  = '{32'd805, 32'd302, 3'b100, 32'd523, 32'd523, 1'b0, 0, 1'b0};
        vecs[3]  = '{32'd805, 32'd302, 3'b010, 32'd292, 32'd292, 1'b0, 10, 1'b1};
        vecs[4]  = '{32'd1, 32'd2, 3'b000, 32'd3, 32'd3, 1'b0, 0, 1'b0};
        vecs[5]  = '{32'd805, 32'd302, 3'b011, 32'd815, 32'd815, 1'b0, 2, 1'b0};
        vecs[6]  = '{32'hFFFF_FFFF, 32'd1, 3'b000, 32'd0, 32'd0, 1'b1, 0, 1'b0};
        vecs[7]  = '{32'd0, 32'd1, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0};
        vecs[8]  = '{32'd805, 32'd302, 3'b101, 32'd0, 32'd0, 1'b1, 0, 1'b0};
        vecs[9]  = '{32'd805, 32'd302, 3'b110, 32'd0, 32'd0, 1'b1, 0, 1'b0};
        vecs[10] = '{32'd805, 32'd302, 3'b111, 32'd0, 32'd0, 1'b1, 0, 1'b0};
        vecs[11] = '{32'hA5A5_0F0F, 32'h5A5A_F0F0, 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1, 1'b0};

        clear        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_a        = '0;
        cmd_b        = '0;
        cmd_op       = '0;
        cmd_expect   = '0;
        rsp_ready    = 1'b0;
        l3_cmd_valid = 1'b0;
        l3_rsp_ready = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        checkValue("reset_rsp_valid", rsp_valid, 0);
        checkValue("reset_alu_op", alu_op, 3'b101);
        checkValue("reset_ops_count", ops_count, 0);
        clear = 1'b1;
        @(posedge clock); #1;
        checkValue("release_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].expv,
                          vecs[i].res, vecs[i].zero);
            checkOutput(vecs[i].hold, vecs[i].second);
        end

        // Reset while a command is waiting on the ALU: it must vanish without a response.
        applyStimulus(32'd805, 32'd302, 3'b000, 32'd1107, 32'd1107, 1'b0);
        clear = 1'b0;
        #2;
        checkValue("midwait_rsp_valid", rsp_valid, 0);
        checkValue("midwait_ops_count", ops_count, 0);
        checkValue("midwait_alu_a", alu_a, 0);
        checkValue("midwait_alu_op", alu_op, 3'b101);
        checkValue("midwait_rsp_result", rsp_result, 0);
        @(posedge clock); #1;
        clear = 1'b1;
        sb.delete();
        ops_model = 0;
        err_model = 0;
        @(posedge clock); #1;
        checkValue("midwait_cmd_ready", cmd_ready, 1);
        repeat (3) begin
            @(posedge clock); #1;
            checkValue("midwait_no_rsp", rsp_valid, 0);
        end

        applyStimulus(32'd805, 32'd302, 3'b011, 32'd815, 32'd815, 1'b0);
        checkOutput(0, 1'b0);
        applyStimulus(32'd805, 32'd302, 3'b011, 32'd814, 32'd815, 1'b0);
        checkOutput(0, 1'b0);

        // Latency-3 instance with a 2-bit counter: timing and saturation at 3.
        for (int k = 1; k <= 4; k++) begin
            n = 0;
            while (!l3_cmd_ready && n < 100) begin
                @(posedge clock); #1;
                n++;
            end
            l3_cmd_valid = 1'b1;
            cmd_a        = 32'd805;
            cmd_b        = 32'd302;
            cmd_op       = 3'b000;
            cmd_expect   = 32'd1107;
            @(posedge clock); #1;
            l3_cmd_valid = 1'b0;
            n = 0;
            while (!l3_rsp_valid && n < 100) begin
                @(posedge clock); #1;
                n++;
            end
            checkValue("l3_latency", n, 4);
            checkValue("l3_rsp_result", l3_rsp_result, 32'd1107);
            checkValue("l3_rsp_zero", l3_rsp_zero, 0);
            l3_rsp_ready = 1'b1;
            @(posedge clock); #1;
            l3_rsp_ready = 1'b0;
            checkValue("l3_ops_count", l3_ops_count, (k > 3) ? 3 : k);
            checkValue("l3_cmd_ready", l3_cmd_ready, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
